// File: rtl/ovs_arb_pkg.sv
// Shared types and constants for the two-source frame arbiter in front of the oversampler.
package ovs_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } ovs_arb_state_t;

  typedef logic req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ovs_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the one not served last.
module ovs_rr_pick2
  import ovs_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last_served,
  output req_idx_t           gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_served;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/axis_ovs_frame_arbiter.sv
// Frame-locked round-robin arbiter sharing one 1-bit AXI-Stream sink between two sources,
// with a post-frame idle gap and a beat watchdog that truncates and drains runaway frames.
//
// state | meaning
// IDLE  | no owner; arbitrate on tvalid and latch the winner
// PASS  | owner's stream forwarded combinationally to m_axis
// DRAIN | frame truncated; owner's tail accepted and discarded up to its tlast
// GAP   | GAP_CYCLES cycles with every tready low
module axis_ovs_frame_arbiter
  import ovs_arb_pkg::*;
#(
  parameter int GAP_CYCLES    = 4,
  parameter int MAX_FRAME_LEN = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  input  logic       s0_axis_tlast,
  output logic       s0_axis_tready,
  input  logic       s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  input  logic       s1_axis_tlast,
  output logic       s1_axis_tready,
  output logic       m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic [1:0] o_grant,
  output logic       o_overrun
);

  localparam int BEAT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam ovs_arb_state_t    END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  ovs_arb_state_t    state_q, state_d;
  req_idx_t          sel_q, last_served_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [1:0]        grant_q;
  logic              overrun_q;

  req_idx_t gnt_idx;
  logic     gnt_valid;
  logic     sel_tdata, sel_tvalid, sel_tlast, sel_tready;
  logic     at_limit, grab, beat_inc, frame_end, truncate;

  ovs_rr_pick2 u_pick (
    .req         ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_served (last_served_q),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid)
  );

  assign sel_tdata  = sel_q ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_tvalid = sel_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_tlast  = sel_q ? s1_axis_tlast  : s0_axis_tlast;
  assign at_limit   = (beat_cnt_q == BEAT_LAST);

  assign s0_axis_tready = sel_tready & ~sel_q;
  assign s1_axis_tready = sel_tready &  sel_q;
  assign o_grant        = grant_q;
  assign o_overrun      = overrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    m_axis_tdata  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    sel_tready    = 1'b0;
    grab          = 1'b0;
    beat_inc      = 1'b0;
    frame_end     = 1'b0;
    truncate      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grab    = 1'b1;
          state_d = PASS;
        end
      end
      PASS: begin
        m_axis_tdata  = sel_tdata;
        m_axis_tvalid = sel_tvalid;
        // The watchdog beat always carries tlast so the sink sees a closed frame.
        m_axis_tlast  = sel_tlast | at_limit;
        sel_tready    = m_axis_tready;
        if (sel_tvalid && m_axis_tready) begin
          beat_inc = 1'b1;
          if (sel_tlast) begin
            frame_end = 1'b1;
            state_d   = END_STATE;
          end else if (at_limit) begin
            truncate = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        sel_tready = 1'b1;
        if (sel_tvalid && sel_tlast) begin
          frame_end = 1'b1;
          state_d   = END_STATE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q         <= 1'b0;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      grant_q       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= truncate;
      if (grab) begin
        sel_q         <= gnt_idx;
        last_served_q <= gnt_idx;
        grant_q       <= idx_to_onehot(gnt_idx);
        beat_cnt_q    <= '0;
      end else if (beat_inc) begin
        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      end
      if (frame_end) begin
        grant_q <= '0;
      end
      if (state_d == GAP && state_q != GAP) begin
        gap_cnt_q <= '0;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_ovs_frame_arbiter.sv
// Bench for axis_ovs_frame_arbiter: cycle table on a zero-gap instance, frame-level
// scoreboard with directed and random traffic on a default instance.
module tb_axis_ovs_frame_arbiter;

  localparam int MAXL = 64;
  localparam int GAPC = 4;
  localparam int SPACING = GAPC + 2;

  typedef struct {
    int           len;
    logic [127:0] bits;
  } frame_t;

  typedef struct {
    int           src;
    int           len;
    logic [127:0] bits;
    int           first;
    int           last;
  } out_t;

  typedef struct {
    logic [6:0] stim;  // s0v s0l s0d s1v s1l s1d mready
    logic [7:0] exp;   // grant[1:0] overrun mv ml md s0r s1r
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic [1:0] s_tvalid, s_tdata, s_tlast;
  logic       s0_tready, s1_tready;
  wire  [1:0] s_tready = {s1_tready, s0_tready};
  logic       m_tdata, m_tvalid, m_tlast, m_tready;
  logic [1:0] o_grant;
  logic       o_overrun;

  axis_ovs_frame_arbiter #(.GAP_CYCLES(GAPC), .MAX_FRAME_LEN(MAXL)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s0_axis_tdata(s_tdata[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tlast(s_tlast[0]), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s_tdata[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tlast(s_tlast[1]), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .o_grant(o_grant), .o_overrun(o_overrun)
  );

  // zero-gap instance
  logic       g_s0v, g_s0l, g_s0d, g_s1v, g_s1l, g_s1d, g_mr;
  logic       g_s0r, g_s1r, g_md, g_mv, g_ml, g_ov;
  logic [1:0] g_grant;

  axis_ovs_frame_arbiter #(.GAP_CYCLES(0), .MAX_FRAME_LEN(MAXL)) u_dut_g0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .s0_axis_tdata(g_s0d), .s0_axis_tvalid(g_s0v), .s0_axis_tlast(g_s0l), .s0_axis_tready(g_s0r),
    .s1_axis_tdata(g_s1d), .s1_axis_tvalid(g_s1v), .s1_axis_tlast(g_s1l), .s1_axis_tready(g_s1r),
    .m_axis_tdata(g_md), .m_axis_tvalid(g_mv), .m_axis_tlast(g_ml), .m_axis_tready(g_mr),
    .o_grant(g_grant), .o_overrun(g_ov)
  );

  int checks = 0;
  int errors = 0;

  frame_t src_q[2][$];
  frame_t exp_q[2][$];
  out_t   out_q[$];
  int     exp_ovr = 0;
  int     vprob = 100;
  int     rmode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- source drivers ----------------
  logic [1:0] acc_s;
  frame_t     cur[2];
  int         beat[2];
  bit         busy[2];

  initial begin
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    busy[0] = 0; busy[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (!rst_n) begin
          busy[s] = 0;
          s_tvalid[s] = 1'b0;
          continue;
        end
        if (busy[s] && acc_s[s]) begin
          beat[s]++;
          if (beat[s] == cur[s].len) busy[s] = 0;
        end
        if (!busy[s] && src_q[s].size() > 0) begin
          cur[s] = src_q[s].pop_front();
          beat[s] = 0;
          busy[s] = 1;
          s_tvalid[s] = 1'b0;
        end
        if (busy[s]) begin
          if (!s_tvalid[s] || acc_s[s]) s_tvalid[s] = ($urandom_range(99) < vprob);
          s_tdata[s] = cur[s].bits[beat[s]];
          s_tlast[s] = (beat[s] == cur[s].len - 1);
        end else begin
          s_tvalid[s] = 1'b0;
        end
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       m_tready = ~m_tready;
        2:       m_tready = ($urandom_range(99) < 75);
        default: m_tready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  int           cyc = 0;
  int           mon_len = 0;
  int           mon_src, mon_first, ovr_cnt = 0, viol = 0;
  int           last_tlast_cyc = -10;
  logic [1:0]   mon_grant;
  logic [127:0] mon_bits;
  bit           prev_ovr = 0;

  initial begin
    forever begin
      int gi;
      out_t o;
      @(negedge clk);
      acc_s = s_tvalid & s_tready;
      cyc++;
      if (!rst_n) begin
        mon_len = 0;
        prev_ovr = 0;
        continue;
      end
      gi = int'(o_grant[1]);
      if (s_tready[0] && o_grant != 2'b01) viol++;
      if (s_tready[1] && o_grant != 2'b10) viol++;
      if (m_tvalid && !(o_grant == 2'b01 || o_grant == 2'b10)) viol++;
      if (m_tvalid && (m_tdata !== s_tdata[gi] || !s_tvalid[gi] || s_tready[gi] !== m_tready)) viol++;
      if (o_overrun) begin
        ovr_cnt++;
        if (prev_ovr || cyc != last_tlast_cyc + 1) viol++;
      end
      prev_ovr = o_overrun;
      if (m_tvalid && m_tready) begin
        if (mon_len == 0) begin
          mon_first = cyc;
          mon_src = gi;
          mon_grant = o_grant;
        end else if (o_grant != mon_grant) begin
          viol++;
        end
        mon_bits[mon_len] = m_tdata;
        mon_len++;
        if (m_tlast) begin
          o.src = mon_src; o.len = mon_len; o.bits = mon_bits;
          o.first = mon_first; o.last = cyc;
          out_q.push_back(o);
          last_tlast_cyc = cyc;
          mon_len = 0;
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  function automatic logic [127:0] rbits();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int s, input int len, input logic [127:0] bits);
    frame_t f;
    f.len = len;
    f.bits = bits;
    src_q[s].push_back(f);
    f.len = (len > MAXL) ? MAXL : len;
    exp_q[s].push_back(f);
    if (len > MAXL) exp_ovr++;
  endtask

  // alt_first >= 0: sources must alternate starting there; gap_exact > 0: exact spacing
  task automatic check_frames(input string tag, input int n, input int alt_first, input int gap_exact);
    out_t   o;
    frame_t e;
    int     prev_last = -1;
    int     exp_src = alt_first;
    int     k = 0;
    int     mism;
    while (out_q.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_frames_seen"}, (out_q.size() >= n) ? n : out_q.size(), n);
    for (int i = 0; i < n && out_q.size() > 0; i++) begin
      o = out_q.pop_front();
      if (alt_first >= 0) begin
        chk({tag, "_src_order"}, o.src, exp_src);
        exp_src = 1 - exp_src;
      end
      chk({tag, "_frame_expected"}, exp_q[o.src].size() > 0, 1);
      if (exp_q[o.src].size() == 0) continue;
      e = exp_q[o.src].pop_front();
      chk({tag, "_len"}, o.len, e.len);
      mism = 0;
      for (int b = 0; b < e.len; b++) if (o.bits[b] !== e.bits[b]) mism++;
      chk({tag, "_bit_errors"}, mism, 0);
      if (prev_last >= 0) begin
        if (gap_exact > 0) chk({tag, "_spacing"}, o.first - prev_last, gap_exact);
        else               chk({tag, "_spacing_min"}, (o.first - prev_last) >= SPACING, 1);
      end
      prev_last = o.last;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[11];

  initial begin
    logic [12:0]  pat13;
    logic [127:0] b13;
    logic [7:0]   act;
    int           k;

    tbl[0]  = '{7'b111_000_1, 8'b00_0_00000};
    tbl[1]  = '{7'b111_000_1, 8'b01_0_11110};
    tbl[2]  = '{7'b000_100_1, 8'b00_0_00000};
    tbl[3]  = '{7'b000_100_0, 8'b10_0_10000};
    tbl[4]  = '{7'b000_100_1, 8'b10_0_10001};
    tbl[5]  = '{7'b101_111_1, 8'b10_0_11101};
    tbl[6]  = '{7'b110_111_1, 8'b00_0_00000};
    tbl[7]  = '{7'b110_111_1, 8'b01_0_11010};
    tbl[8]  = '{7'b110_111_1, 8'b00_0_00000};
    tbl[9]  = '{7'b110_111_1, 8'b10_0_11101};
    tbl[10] = '{7'b000_000_1, 8'b00_0_00000};

    {g_s0v, g_s0l, g_s0d, g_s1v, g_s1l, g_s1d, g_mr} = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_grant, o_overrun, m_tvalid, s_tready}, 0);
    #1 rst_n = 1'b1;

    // zero-gap instance, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      {g_s0v, g_s0l, g_s0d, g_s1v, g_s1l, g_s1d, g_mr} = tbl[i].stim;
      @(negedge clk);
      act = {g_grant, g_ov, g_mv, g_ml, g_md, g_s0r, g_s1r};
      checks++;
      if (act !== tbl[i].exp) begin
        errors++;
        $display("FAIL g0_row%0d actual=%b expected=%b", i, act, tbl[i].exp);
      end
    end

    // single requester, back-to-back frames
    pat13 = 13'b1111100110101;
    b13 = '0;
    for (int i = 0; i < 13; i++) b13[i] = pat13[12-i];
    send(0, 13, b13);
    send(0, 3, rbits());
    check_frames("single", 2, -1, SPACING);
    chk("single_overrun", ovr_cnt, exp_ovr);

    // contention: both always valid, last served was s0
    for (int i = 0; i < 4; i++) begin
      send(0, 8, rbits());
      send(1, 8, rbits());
    end
    check_frames("contend", 8, 1, SPACING);

    // backpressure on an s1 frame
    rmode = 1;
    send(1, 10, rbits());
    check_frames("backpr", 1, -1, 0);
    rmode = 0;
    chk("backpr_viol", viol, 0);

    // overrun on s0 with s1 waiting behind it
    send(0, 70, rbits());
    send(1, 5, rbits());
    check_frames("overrun", 2, 0, SPACING + 6);
    chk("overrun_count", ovr_cnt, exp_ovr);

    // boundary: exact max length, then single beat
    send(0, MAXL, rbits());
    check_frames("maxlen", 1, -1, 0);
    send(1, 1, rbits());
    check_frames("onebeat", 1, -1, 0);
    chk("boundary_overrun_count", ovr_cnt, exp_ovr);

    // random traffic
    vprob = 60;
    rmode = 2;
    for (int i = 0; i < 30; i++) send($urandom_range(1), $urandom_range(80, 1), rbits());
    check_frames("random", 30, -1, 0);
    vprob = 100;
    rmode = 0;
    repeat (10) @(negedge clk);
    chk("random_overrun_count", ovr_cnt, exp_ovr);
    chk("protocol_viol", viol, 0);

    // reset on beat 5 of an s1 frame
    send(1, 20, rbits());
    k = 0;
    while (mon_len != 5 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk("pre_reset_beat", mon_len, 5);
    chk("pre_reset_grant", o_grant, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_grant, o_overrun, m_tvalid, s_tready}, 0);
    chk("async_reset_g0", {g_grant, g_ov, g_mv, g_s0r, g_s1r}, 0);
    repeat (2) @(negedge clk);
    src_q[0].delete(); src_q[1].delete();
    exp_q[0].delete(); exp_q[1].delete();
    out_q.delete();
    #1 rst_n = 1'b1;
    send(0, 1, rbits());
    send(1, 1, rbits());
    check_frames("post_reset", 2, 0, SPACING);
    chk("final_viol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
